// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and constants for the burst memory responder.
package pmem_pkg;
   localparam int BURST_LEN        = 4;
   localparam int LINE_OFFSET_BITS = 5;
   localparam int BEAT_BITS        = 64;
   typedef logic [BURST_LEN*BEAT_BITS-1:0] pmem_line_t;
   typedef logic [BEAT_BITS-1:0]           pmem_beat_t;
   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_state_t;
endpackage

// File: rtl/pmem_line_ram.sv
// pmem_line_ram: line storage with per-beat write enables and a registered full-line read.
module pmem_line_ram
   import pmem_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                 clk,
   input  logic [IDX_BITS-1:0]  i_waddr,
   input  logic [BURST_LEN-1:0] i_we,
   input  pmem_beat_t           i_wdata,
   input  logic [IDX_BITS-1:0]  i_raddr,
   output pmem_line_t           o_rdata
);
   pmem_line_t r_mem [2**IDX_BITS];
   always_ff @(posedge clk) begin
      for (int b = 0; b < BURST_LEN; b++)
         if (i_we[b]) r_mem[i_waddr][b*BEAT_BITS +: BEAT_BITS] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: burst memory responder with programmable first-beat latency.
module pmem_responder
   import pmem_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int LATENCY  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pmem_read,
   input  logic        pmem_write,
   input  logic [31:0] pmem_addr,
   input  logic [63:0] pmem_wdata,
   output logic        pmem_resp,
   output logic [63:0] pmem_rdata,
   output logic        proto_err
);
   pmem_state_t          r_state, w_next;
   logic [3:0]           r_cnt;
   logic [1:0]           r_beat;
   logic                 r_wr, r_err;
   logic [IDX_BITS-1:0]  r_idx;
   logic [31:0]          r_addr;
   logic                 w_accept, w_err_set, w_held, w_other;
   logic [IDX_BITS-1:0]  w_idx, w_raddr;
   logic [BURST_LEN-1:0] w_we;
   pmem_line_t           w_line;

   assign w_idx      = pmem_addr[LINE_OFFSET_BITS +: IDX_BITS];
   assign w_held     = r_wr ? pmem_write : pmem_read;
   assign w_other    = r_wr ? pmem_read : pmem_write;
   // Idle read address follows the bus so the line is ready even at LATENCY 1.
   assign w_raddr    = (r_state == IDLE) ? w_idx : r_idx;
   assign w_we       = (r_state == BURST && r_wr && w_held) ? (BURST_LEN'(1) << r_beat) : '0;
   assign pmem_resp  = r_state == BURST;
   assign pmem_rdata = (pmem_resp && !r_wr) ? w_line[{r_beat, 6'd0} +: BEAT_BITS] : '0;
   assign proto_err  = r_err;

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_err_set = 1'b0;
      case (r_state)
         IDLE: begin
            w_err_set = pmem_read & pmem_write;
            w_accept  = pmem_read ^ pmem_write;
            if (w_accept) w_next = (LATENCY == 1) ? BURST : WAIT;
         end
         WAIT, BURST: begin
            w_err_set = !w_held || w_other || pmem_addr != r_addr;
            if (!w_held) w_next = IDLE;
            else if (r_state == WAIT) w_next = (r_cnt <= 4'd1) ? BURST : WAIT;
            else w_next = (r_beat == 2'd3) ? DONE : BURST;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_wr    <= 1'b0;
         r_idx   <= '0;
         r_addr  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= r_err | w_err_set;
         r_beat  <= (r_state == BURST && w_next == BURST) ? r_beat + 2'd1 : 2'd0;
         if (w_accept) begin
            r_wr   <= pmem_write;
            r_idx  <= w_idx;
            r_addr <= pmem_addr;
            r_cnt  <= 4'(LATENCY - 1);
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   pmem_line_ram #(.IDX_BITS(IDX_BITS)) u_ram (
      .clk     (clk),
      .i_waddr (r_idx),
      .i_we    (w_we),
      .i_wdata (pmem_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_line)
   );
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed scenario tests for the burst memory responder.
module tb_pmem_responder;
   import pmem_pkg::*;
   localparam int LAT = 3;
   logic        clk = 1'b0, rst = 1'b0, pmem_read = 1'b0, pmem_write = 1'b0;
   logic [31:0] pmem_addr = '0;
   logic [63:0] pmem_wdata = '0;
   logic        pmem_resp, proto_err;
   logic [63:0] pmem_rdata;
   int          n_checks = 0, n_fail = 0;
   logic [63:0] wbeats [4];
   logic [63:0] cap [4];
   logic [63:0] line_a [4] = '{64'h1111111111111111, 64'h2222222222222222,
                               64'h3333333333333333, 64'h4444444444444444};
   logic [63:0] line_b [4] = '{64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
                               64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD};
   logic [7:0]  resp_bits;
   logic        leak;

   pmem_responder #(.IDX_BITS(6), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_resp  (pmem_resp),
      .pmem_rdata (pmem_rdata),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   // Called at a negedge; that cycle is k. Records resp for cycles k..k+7 and read beats.
   task automatic burst(input logic wr, input logic [31:0] addr, input bit hold);
      int bi = 0;
      pmem_read  = !wr;
      pmem_write = wr;
      pmem_addr  = addr;
      leak       = 1'b0;
      resp_bits  = '0;
      cap        = '{default: '0};
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         pmem_wdata   = wbeats[bi < 4 ? bi : 3];
         resp_bits[i] = pmem_resp;
         if (pmem_resp && bi < 4) begin
            cap[bi] = pmem_rdata;
            bi++;
         end else if (pmem_rdata !== '0) leak = 1'b1;
         if (i == 7 && !hold) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_checks++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", pmem_resp); end
      n_checks++; if (pmem_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", pmem_rdata); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", proto_err); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read;
      wbeats = line_a;
      burst(1'b1, 32'h0000_0040, 1'b0);
      n_checks++; if (resp_bits !== 8'h78) begin n_fail++; $display("FAIL write_resp_timing: got %b want 01111000", resp_bits); end
      wbeats = '{default: '0};
      burst(1'b0, 32'h0000_0040, 1'b0);
      n_checks++; if (resp_bits !== 8'h78) begin n_fail++; $display("FAIL read_resp_timing: got %b want 01111000", resp_bits); end
      for (int b = 0; b < 4; b++) begin
         n_checks++; if (cap[b] !== line_a[b]) begin n_fail++; $display("FAIL read_beat%0d: got %h want %h", b, cap[b], line_a[b]); end
      end
      n_checks++; if (leak !== 1'b0) begin n_fail++; $display("FAIL read_rdata_idle: got %b want 0", leak); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL write_read_err: got %b want 0", proto_err); end
   endtask

   task automatic test_alias;
      burst(1'b0, 32'h0000_0840, 1'b0);
      n_checks++; if (resp_bits !== 8'h78) begin n_fail++; $display("FAIL alias_resp_timing: got %b want 01111000", resp_bits); end
      for (int b = 0; b < 4; b++) begin
         n_checks++; if (cap[b] !== line_a[b]) begin n_fail++; $display("FAIL alias_beat%0d: got %h want %h", b, cap[b], line_a[b]); end
      end
   endtask

   task automatic test_back_to_back;
      burst(1'b0, 32'h0000_0040, 1'b1);
      n_checks++; if (resp_bits !== 8'h78) begin n_fail++; $display("FAIL b2b_first_timing: got %b want 01111000", resp_bits); end
      n_checks++; if (cap[3] !== line_a[3]) begin n_fail++; $display("FAIL b2b_first_beat3: got %h want %h", cap[3], line_a[3]); end
      burst(1'b0, 32'h0000_0040, 1'b0);
      n_checks++; if (resp_bits !== 8'h78) begin n_fail++; $display("FAIL b2b_second_timing: got %b want 01111000", resp_bits); end
      n_checks++; if (cap[0] !== line_a[0]) begin n_fail++; $display("FAIL b2b_second_beat0: got %h want %h", cap[0], line_a[0]); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", proto_err); end
   endtask

   task automatic test_reset_mid_write;
      int bi = 0;
      pmem_write = 1'b1;
      pmem_addr  = 32'h0000_0040;
      for (int i = 0; i < LAT + 2; i++) begin
         pmem_wdata = line_b[bi];
         if (pmem_resp) bi++;
         @(negedge clk);
      end
      pmem_wdata = line_b[bi];
      n_checks++; if (pmem_resp !== 1'b1) begin n_fail++; $display("FAIL midwr_beat2_resp: got %b want 1", pmem_resp); end
      rst = 1'b0;
      #1;
      n_checks++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL midwr_reset_resp: got %b want 0", pmem_resp); end
      n_checks++; if (pmem_rdata !== 64'h0) begin n_fail++; $display("FAIL midwr_reset_rdata: got %h want 0", pmem_rdata); end
      pmem_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      burst(1'b0, 32'h0000_0040, 1'b0);
      n_checks++; if (cap[0] !== line_b[0]) begin n_fail++; $display("FAIL midwr_beat0: got %h want %h", cap[0], line_b[0]); end
      n_checks++; if (cap[1] !== line_b[1]) begin n_fail++; $display("FAIL midwr_beat1: got %h want %h", cap[1], line_b[1]); end
      n_checks++; if (cap[2] !== line_a[2]) begin n_fail++; $display("FAIL midwr_beat2: got %h want %h", cap[2], line_a[2]); end
      n_checks++; if (cap[3] !== line_a[3]) begin n_fail++; $display("FAIL midwr_beat3: got %h want %h", cap[3], line_a[3]); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL midwr_err: got %b want 0", proto_err); end
   endtask

   task automatic test_read_drop_wait;
      int n_resp = 0;
      pmem_read = 1'b1;
      pmem_addr = 32'h0000_0040;
      @(negedge clk);
      n_checks++; if (dut.r_state !== WAIT) begin n_fail++; $display("FAIL drop_in_wait: got %0d want %0d", dut.r_state, WAIT); end
      pmem_read = 1'b0;
      @(negedge clk);
      n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL drop_state: got %0d want %0d", dut.r_state, IDLE); end
      for (int i = 0; i < 8; i++) begin
         if (pmem_resp) n_resp++;
         @(negedge clk);
      end
      n_checks++; if (n_resp !== 0) begin n_fail++; $display("FAIL drop_resp_count: got %0d want 0", n_resp); end
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", proto_err); end
   endtask

   task automatic test_both_high;
      int n_resp = 0;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL both_err_cleared: got %b want 0", proto_err); end
      rst        = 1'b1;
      pmem_read  = 1'b1;
      pmem_write = 1'b1;
      pmem_addr  = 32'h0000_0040;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pmem_resp) n_resp++;
      end
      n_checks++; if (n_resp !== 0) begin n_fail++; $display("FAIL both_resp_count: got %0d want 0", n_resp); end
      n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", proto_err); end
      n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL both_state: got %0d want %0d", dut.r_state, IDLE); end
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_alias;
      test_back_to_back;
      test_reset_mid_write;
      test_read_drop_wait;
      test_both_high;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
